// File: rtl/pipe_scroller.sv
// Pipe motion controller: scrolls two pipes left once per frame, recycles each
// to the right edge with a pseudo-random gap, counts passed pipes and freezes
// on collision. All outputs change only in the cycle after frame_tick.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | pipes held at their start positions, waiting for start
// RUN   | pipes scroll on every frame_tick, scoring active
// DEAD  | everything frozen after a collision, start returns to IDLE
module pipe_scroller #(
    parameter int          SCREEN_W   = 640,
    parameter int          PIPE_WIDTH = 40,
    parameter int          SPEED      = 2,
    parameter int          PIPE1_INIT = 300,
    parameter int          PIPE2_INIT = 550,
    parameter int          GAP1_INIT  = 180,
    parameter int          GAP2_INIT  = 240,
    parameter int          GAP_MIN    = 40,
    parameter int          BIRD_X     = 100,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       collide,
    output logic [9:0] pipe1_x,
    output logic [9:0] pipe2_x,
    output logic [8:0] gap1_top,
    output logic [8:0] gap2_top,
    output logic [7:0] score,
    output logic       score_pulse,
    output logic       running
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    localparam logic [9:0]  SCREEN_W_V = 10'(SCREEN_W);
    localparam logic [9:0]  SPEED_V    = 10'(SPEED);
    localparam logic [9:0]  P1_INIT_V  = 10'(PIPE1_INIT);
    localparam logic [9:0]  P2_INIT_V  = 10'(PIPE2_INIT);
    localparam logic [8:0]  G1_INIT_V  = 9'(GAP1_INIT);
    localparam logic [8:0]  G2_INIT_V  = 9'(GAP2_INIT);
    localparam logic [8:0]  GAP_MIN_V  = 9'(GAP_MIN);
    localparam logic [10:0] WIDTH_V    = 11'(PIPE_WIDTH);
    localparam logic [10:0] BIRD_X_V   = 11'(BIRD_X);

    state_t      state, next_state;
    logic [15:0] lfsr;

    logic        move;
    logic        reload;
    logic        p1_wrap, p2_wrap;
    logic [9:0]  p1_next, p2_next;
    logic        p1_score, p2_score;
    logic [8:0]  score_sum;
    logic [7:0]  score_next;

    // Free-running Galois LFSR, taps 16,14,13,11.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; collide takes priority over start and frame_tick in RUN.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start)   next_state = RUN;
            RUN:     if (collide) next_state = DEAD;
            DEAD:    if (start)   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Candidate pipe positions and pass detection for the current frame.
    always_comb begin
        move    = (state == RUN) && frame_tick && !collide;
        reload  = (state == DEAD) && start;
        p1_wrap = pipe1_x < SPEED_V;
        p2_wrap = pipe2_x < SPEED_V;
        p1_next = p1_wrap ? SCREEN_W_V : pipe1_x - SPEED_V;
        p2_next = p2_wrap ? SCREEN_W_V : pipe2_x - SPEED_V;
        // A recycled pipe jumps right, so it can never cross the bird here.
        p1_score = !p1_wrap
                   && (({1'b0, pipe1_x} + WIDTH_V) > BIRD_X_V)
                   && (({1'b0, p1_next} + WIDTH_V) <= BIRD_X_V);
        p2_score = !p2_wrap
                   && (({1'b0, pipe2_x} + WIDTH_V) > BIRD_X_V)
                   && (({1'b0, p2_next} + WIDTH_V) <= BIRD_X_V);
        score_sum  = {1'b0, score} + {7'd0, p1_score} + {7'd0, p2_score};
        score_next = score_sum[8] ? 8'hFF : score_sum[7:0];
    end

    // Pipe, gap and score registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe1_x     <= P1_INIT_V;
            pipe2_x     <= P2_INIT_V;
            gap1_top    <= G1_INIT_V;
            gap2_top    <= G2_INIT_V;
            score       <= 8'd0;
            score_pulse <= 1'b0;
        end else begin
            score_pulse <= 1'b0;
            if (reload) begin
                pipe1_x  <= P1_INIT_V;
                pipe2_x  <= P2_INIT_V;
                gap1_top <= G1_INIT_V;
                gap2_top <= G2_INIT_V;
                score    <= 8'd0;
            end else if (move) begin
                pipe1_x     <= p1_next;
                pipe2_x     <= p2_next;
                if (p1_wrap) gap1_top <= GAP_MIN_V + {1'b0, lfsr[7:0]};
                if (p2_wrap) gap2_top <= GAP_MIN_V + {1'b0, lfsr[15:8]};
                score       <= score_next;
                score_pulse <= p1_score || p2_score;
            end
        end
    end

    assign running = (state == RUN);

endmodule

// File: doc/pipe_scroller.md
Name: pipe_scroller

Overview:
- Motion/state controller sitting directly upstream of the pipe renderer. Supplies the two pipe X positions and gap-top rows that the renderer compares against hCount/vCount.
- Scrolls pipes left once per video frame, recycles each pipe to the right edge with a pseudo-random gap, counts passed pipes and freezes on collision.
- All outputs are registered and change only in the cycle after frame_tick (issued at vblank start), so they are stable throughout active video.

Parameters:
- SCREEN_W, 640, X value a recycled pipe is reloaded to (just off-screen right)
- PIPE_WIDTH, 40, pipe width in pixels; must match the renderer
- SPEED, 2, pixels moved per frame_tick
- PIPE1_INIT, 300, pipe 1 start X
- PIPE2_INIT, 550, pipe 2 start X
- GAP1_INIT, 180, pipe 1 start gap top
- GAP2_INIT, 240, pipe 2 start gap top
- GAP_MIN, 40, minimum randomized gap top
- BIRD_X, 100, bird column used for scoring
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per frame, at vblank start
- start  in  1  start/restart request, level or pulse
- collide  in  1  collision flag from the bird/pipe overlap logic
- pipe1_x  out  10  pipe 1 left edge X
- pipe2_x  out  10  pipe 2 left edge X
- gap1_top  out  9  pipe 1 gap top row
- gap2_top  out  9  pipe 2 gap top row
- score  out  8  pipes passed, saturates at 255
- score_pulse  out  1  one-cycle pulse per pipe passed
- running  out  1  high in RUN state

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE
  - pipe1_x=PIPE1_INIT, pipe2_x=PIPE2_INIT
  - gap1_top=GAP1_INIT, gap2_top=GAP2_INIT
  - score=0, score_pulse=0, running=0
  - lfsr=LFSR_SEED
- LFSR:
  - 16-bit Galois, taps 16,14,13,11 (mask 16'hB400).
  - Shifts every clk in every state, including IDLE and DEAD.
- States:
  - IDLE: pipes held at init values; frame_tick ignored. start=1 -> RUN.
  - RUN: running=1. collide=1 -> DEAD. Otherwise each frame_tick updates both pipes (below).
  - DEAD: all outputs frozen; frame_tick ignored. start=1 -> IDLE, reloading all init positions/gaps and clearing score. Reload happens on that transition clock edge.
- Per-pipe update on frame_tick in RUN:
  - If x < SPEED: x <= SCREEN_W; gap <= GAP_MIN + r.
    - r = lfsr[7:0] for pipe 1, lfsr[15:8] for pipe 2, using the current lfsr value.
    - Gap range is 40..295, so gap+120 <= 415 < 480.
  - Else: x <= x - SPEED; gap unchanged.
  - All arithmetic is 10-bit unsigned; no negative X is ever produced.
- Scoring:
  - A pipe scores on the tick where old x+PIPE_WIDTH > BIRD_X and new x+PIPE_WIDTH <= BIRD_X (11-bit compare).
  - Recycling updates never score.
  - score_pulse is high for exactly the cycle after that tick.
  - If both pipes score on the same tick, score += 2 with a single pulse.
  - score saturates at 255.
- Simultaneous events:
  - collide and frame_tick in the same RUN cycle: no movement; go to DEAD.
  - collide and start in RUN: collide wins.
  - collide in IDLE: ignored.
  - start in RUN: ignored.
- Latency: outputs reflect a frame_tick one clk later.
- Reset mid-RUN returns immediately to the reset values above.

Test Plan:
- Reset -> pipe1_x=300, pipe2_x=550, gap 180/240, score=0, running=0. Then 10 frame_ticks with start=0 -> values unchanged.
- Pulse start, then 1 frame_tick -> running=1, pipe1_x=298, pipe2_x=548, gaps unchanged.
- From start, 120 ticks -> pipe1_x=60, score_pulse high for one cycle, score=1. Tick 121 -> no pulse. Tick 245 -> pipe2_x=60 (550-490), score=2.
- Tick 150 -> pipe1_x=0. Tick 151 -> pipe1_x=640, gap1_top = 40 + lfsr[7:0] (checked against reference-model LFSR, range 40..295), pipe2_x=248.
- In RUN, assert collide in the same cycle as frame_tick -> positions unchanged, running=0. Further ticks -> frozen. Pulse start -> 300/550/180/240, score=0, IDLE.
- Assert rst_n=0 mid-RUN, asynchronously between clock edges -> all outputs return to reset values before the next clk edge.
